// File: rtl/uart_pkg.sv
// uart_pkg: shared UART scheduler state type, framing constants and ID width helper
package uart_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE, GAP} sched_state_t;
    localparam int   DATA_W_DEF = 8;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam int   STOP_BITS  = 1;
    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// rr_pick: combinational round-robin priority encoder; first set req at or after rr_ptr wins
module rr_pick import uart_pkg::*; #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]       req,
    input  logic [id_w(NUM_REQ)-1:0] rr_ptr,
    output logic                     found,
    output logic [id_w(NUM_REQ)-1:0] idx
);
    localparam int IW = id_w(NUM_REQ);
    always_comb begin
        found = |req;
        idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req[(int'(rr_ptr) + i) % NUM_REQ]) idx = IW'((int'(rr_ptr) + i) % NUM_REQ);
    end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART TX frame engine between NUM_REQ producers.
// Define UART_SCHED_TIMEOUT_EN to build the WAIT_DONE watchdog driving timeout_err.
module uart_tx_sched import uart_pkg::*; #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int GAP_CYC     = 16,
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    input  logic                      tx_busy,
    input  logic                      tx_done,
    output logic                      tx_load,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      active,
    output logic [id_w(NUM_REQ)-1:0]  cur_id,
    output logic                      timeout_err
);
    localparam int IW = id_w(NUM_REQ);
    localparam int GW = id_w(GAP_CYC + 1);

    sched_state_t      state, state_n;
    logic [IW-1:0]     rr_ptr, pick_idx;
    logic [DATA_W-1:0] hold_reg;
    logic [GW-1:0]     gap_cnt;
    logic              found, grant, gap_last, abort;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (req),
        .rr_ptr(rr_ptr),
        .found (found),
        .idx   (pick_idx)
    );

    assign grant    = state == IDLE && found;
    assign gap_last = int'(gap_cnt) == GAP_CYC - 1;

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_n;

    always_comb
        state_n = grant                                      ? LOAD :
                  (state == LOAD && !tx_busy)                ? WAIT_DONE :
                  (state == WAIT_DONE && (tx_done || abort)) ? (GAP_CYC == 0 ? IDLE : GAP) :
                  (state == GAP && gap_last)                 ? IDLE : state;

    always_comb begin
        tx_load = state == LOAD && !tx_busy;
        active  = state != IDLE;
        tx_data = hold_reg;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            rr_ptr   <= '0;
            hold_reg <= '0;
            cur_id   <= '0;
            ack      <= '0;
            gap_cnt  <= '0;
        end else begin
            ack     <= grant ? NUM_REQ'(1) << pick_idx : '0;
            gap_cnt <= (state == GAP && !gap_last) ? gap_cnt + 1'b1 : '0;
            if (grant) begin
                hold_reg <= req_data[int'(pick_idx)*DATA_W +: DATA_W];
                cur_id   <= pick_idx;
                rr_ptr   <= IW'((int'(pick_idx) + 1) % NUM_REQ);
            end
        end

`ifdef UART_SCHED_TIMEOUT_EN
    localparam int TW = id_w(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;
    // tmo_cnt is zero in the first WAIT_DONE cycle, so abort lands on the TIMEOUT_CYC-th one
    assign abort = state == WAIT_DONE && !tx_done && int'(tmo_cnt) == TIMEOUT_CYC - 1;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            tmo_cnt <= state == WAIT_DONE ? tmo_cnt + 1'b1 : '0;
            if (abort) timeout_err <= 1'b1;
        end
`else
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif
endmodule
